// File: rtl/op_seq_pkg.sv
// Shared definitions for the layer-operation sequencer: default widths and
// the FSM state encoding.
package op_seq_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/op_sequencer_if.sv
// Bundle of control-register, operand-fetch, result-return and cache-write
// signals between the sequencer (master) and its environment (slave).
interface op_sequencer_if
  import op_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  // Handshake: a fetch transfers on a clock edge where srcValid and srcReady
  // are both high; srcAddr holds until then. resValid is a one-shot strobe
  // with no back-pressure, honoured only while the sequencer waits for it.
  logic              beginOp;
  logic              readyForNextOp;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] dest;
  logic [ADDR_W-1:0] numOps;
  logic              writeReverse;
  logic [ADDR_W-1:0] srcAddr;
  logic              srcValid;
  logic              srcReady;
  logic [DATA_W-1:0] resData;
  logic              resValid;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              wrEn;
  logic [ADDR_W-1:0] opCount;
  logic              done;

  modport master (
    input  beginOp, offset, dest, numOps, writeReverse, srcReady, resData, resValid,
    output readyForNextOp, srcAddr, srcValid, wrAddr, wrData, wrEn, opCount, done
  );

  modport slave (
    output beginOp, offset, dest, numOps, writeReverse, srcReady, resData, resValid,
    input  readyForNextOp, srcAddr, srcValid, wrAddr, wrData, wrEn, opCount, done
  );

endinterface

// File: rtl/op_addr_gen.sv
// Source and destination address generation; all arithmetic wraps silently
// modulo 2^ADDR_W.
module op_addr_gen
  import op_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] i_offset,
  input  logic [ADDR_W-1:0] i_dest,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic              i_reverse,
  output logic [ADDR_W-1:0] o_src_addr,
  output logic [ADDR_W-1:0] o_wr_addr
);

  assign o_src_addr = i_offset + i_idx;
  assign o_wr_addr  = i_reverse ? (i_dest - i_idx) : (i_dest + i_idx);

endmodule

// File: rtl/op_sequencer.sv
// Sequences numOps fetch/compute/write operations: issue an operand address,
// wait for the datapath result, write it to the cache, repeat.
module op_sequencer
  import op_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  op_sequencer_if.master bus,
  output state_e         o_dbg_state
);

  state_e            r_state;
  state_e            w_next;
  logic [ADDR_W-1:0] r_offset;
  logic [ADDR_W-1:0] r_dest;
  logic [ADDR_W-1:0] r_num;
  logic              r_rev;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_op_count;
  logic [DATA_W-1:0] r_res;
  logic [ADDR_W-1:0] w_idx_inc;
  logic [ADDR_W-1:0] w_src_addr;
  logic [ADDR_W-1:0] w_wr_addr;

  assign w_idx_inc = r_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.beginOp) w_next = (bus.numOps == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (bus.srcReady) w_next = ST_WAIT;
      ST_WAIT:  if (bus.resValid) w_next = ST_WRITE;
      ST_WRITE: w_next = (w_idx_inc == r_num) ? ST_DONE : ST_ISSUE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Operation parameters are captured once so later register writes cannot
  // disturb an operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_offset   <= '0;
      r_dest     <= '0;
      r_num      <= '0;
      r_rev      <= 1'b0;
      r_idx      <= '0;
      r_op_count <= '0;
      r_res      <= '0;
    end else begin
      if (r_state == ST_IDLE && bus.beginOp) begin
        r_offset   <= bus.offset;
        r_dest     <= bus.dest;
        r_num      <= bus.numOps;
        r_rev      <= bus.writeReverse;
        r_idx      <= '0;
        r_op_count <= '0;
      end
      if (r_state == ST_WAIT && bus.resValid) r_res <= bus.resData;
      if (r_state == ST_WRITE) begin
        r_idx      <= w_idx_inc;
        r_op_count <= r_op_count + 1'b1;
      end
    end
  end

  op_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .i_offset   (r_offset),
    .i_dest     (r_dest),
    .i_idx      (r_idx),
    .i_reverse  (r_rev),
    .o_src_addr (w_src_addr),
    .o_wr_addr  (w_wr_addr)
  );

  // Strobes decode only the state register, so no input reaches wrEn or done.
  assign bus.readyForNextOp = (r_state == ST_IDLE);
  assign bus.srcValid       = (r_state == ST_ISSUE);
  assign bus.wrEn           = (r_state == ST_WRITE);
  assign bus.done           = (r_state == ST_DONE);
  assign bus.srcAddr        = w_src_addr;
  assign bus.wrAddr         = w_wr_addr;
  assign bus.wrData         = r_res;
  assign bus.opCount        = r_op_count;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: reactive datapath driver, negedge write
// monitor, expected-value queues for addresses and writes.
module tb_op_sequencer;
  import op_seq_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;

  logic   clk;
  logic   rst_n;
  state_e dbg_state;

  op_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  op_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_src_cycles = 0;
  int n_unstable = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [15:0] exp_src_q[$];
  logic [15:0] got_src_q[$];

  always @(negedge clk) begin
    if (rst_n && bus.wrEn) got_q.push_back({bus.wrAddr, bus.wrData});
    if (rst_n && bus.srcValid) n_src_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
    exp_src_q.delete();
    got_src_q.delete();
    n_unstable = 0;
  endtask

  // scoreboard: compare captured writes and source addresses in order
  task automatic compare_queues(input string tag);
    check({tag, "_n_writes"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_write"}, got_q.pop_front(), exp_q.pop_front());
    check({tag, "_n_src"}, got_src_q.size(), exp_src_q.size());
    while (exp_src_q.size() > 0 && got_src_q.size() > 0)
      check({tag, "_srcAddr"}, {16'h0, got_src_q.pop_front()}, {16'h0, exp_src_q.pop_front()});
    check({tag, "_src_stable"}, n_unstable, 0);
  endtask

  // driver: pulse beginOp, then answer fetches after rdy_dly cycles and
  // return results after res_dly cycles; resData = 0xA0 + op index
  task automatic run_op(input logic [15:0] off, input logic [15:0] dst, input logic [15:0] n,
                        input logic rev, input int rdy_dly, input int res_dly,
                        input int mid_begin, input int budget, output int cycles);
    int phase;
    int cnt;
    int k;
    logic hs;
    logic [15:0] first_addr;
    bus.offset = off; bus.dest = dst; bus.numOps = n; bus.writeReverse = rev;
    bus.beginOp = 1'b1;
    step();
    bus.beginOp = 1'b0;
    bus.offset = 16'h5555; bus.dest = 16'hAAAA; bus.numOps = 16'h0001; bus.writeReverse = ~rev;
    cycles = 1; phase = 0; cnt = 0; k = 0; first_addr = '0;
    while (!bus.done && cycles < budget) begin
      hs = 1'b0;
      bus.beginOp  = (cycles == mid_begin);
      bus.srcReady = 1'b0;
      bus.resValid = 1'b0;
      if (phase == 0 && bus.srcValid) begin
        if (cnt == 0) first_addr = bus.srcAddr;
        else if (bus.srcAddr !== first_addr) n_unstable++;
        if (cnt >= rdy_dly) begin
          bus.srcReady = 1'b1;
          hs = 1'b1;
          got_src_q.push_back(bus.srcAddr);
        end
        cnt++;
      end else if (phase == 1) begin
        if (cnt >= res_dly) begin
          bus.resValid = 1'b1;
          bus.resData  = 16'h00A0 + 16'(k);
        end
        cnt++;
      end
      step();
      cycles++;
      if (hs) begin
        phase = 1; cnt = 0;
      end else if (bus.resValid) begin
        phase = 0; cnt = 0; k++;
      end
    end
    bus.beginOp = 1'b0; bus.srcReady = 1'b0; bus.resValid = 1'b0;
  endtask

  task automatic check_done_tail(input string tag, input logic [15:0] exp_count);
    check({tag, "_done"}, bus.done, 1'b1);
    check({tag, "_opCount"}, bus.opCount, exp_count);
    step();
    check({tag, "_done_one_cycle"}, bus.done, 1'b0);
    check({tag, "_ready_after"}, bus.readyForNextOp, 1'b1);
    check({tag, "_opCount_hold"}, bus.opCount, exp_count);
  endtask

  initial begin
    int cyc;
    int src_before;
    rst_n = 1'b0;
    bus.beginOp = 1'b0; bus.offset = '0; bus.dest = '0; bus.numOps = '0;
    bus.writeReverse = 1'b0; bus.srcReady = 1'b0; bus.resData = '0; bus.resValid = 1'b0;

    // reset state
    step();
    check("rst_ready", bus.readyForNextOp, 1'b1);
    check("rst_srcValid", bus.srcValid, 1'b0);
    check("rst_wrEn", bus.wrEn, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_opCount", bus.opCount, 16'h0);
    check("rst_srcAddr", bus.srcAddr, 16'h0);
    check("rst_wrAddr", bus.wrAddr, 16'h0);
    check("rst_wrData", bus.wrData, 16'h0);
    step();
    rst_n = 1'b1;
    step();

    // ascending writes, minimum latency
    clear_queues();
    exp_src_q.push_back(16'h0010); exp_src_q.push_back(16'h0011); exp_src_q.push_back(16'h0012);
    exp_q.push_back(32'h0100_00A0); exp_q.push_back(32'h0101_00A1); exp_q.push_back(32'h0102_00A2);
    run_op(16'h0010, 16'h0100, 16'd3, 1'b0, 0, 0, -1, 200, cyc);
    check("asc_cycles", cyc, 10);
    check_done_tail("asc", 16'd3);
    compare_queues("asc");
    step();

    // descending writes
    clear_queues();
    exp_src_q.push_back(16'h0010); exp_src_q.push_back(16'h0011); exp_src_q.push_back(16'h0012);
    exp_q.push_back(32'h0100_00A0); exp_q.push_back(32'h00FF_00A1); exp_q.push_back(32'h00FE_00A2);
    run_op(16'h0010, 16'h0100, 16'd3, 1'b1, 0, 0, -1, 200, cyc);
    check("desc_cycles", cyc, 10);
    check_done_tail("desc", 16'd3);
    compare_queues("desc");
    step();

    // zero ops: done next cycle, nothing issued or written
    clear_queues();
    src_before = n_src_cycles;
    run_op(16'h0010, 16'h0100, 16'd0, 1'b0, 0, 0, -1, 200, cyc);
    check("zero_cycles", cyc, 1);
    check_done_tail("zero", 16'd0);
    check("zero_no_srcValid", n_src_cycles - src_before, 0);
    compare_queues("zero");
    step();

    // back-pressure, late results, ignored mid-op beginOp
    clear_queues();
    exp_src_q.push_back(16'h0200); exp_src_q.push_back(16'h0201); exp_src_q.push_back(16'h0202);
    exp_q.push_back(32'h0300_00A0); exp_q.push_back(32'h0301_00A1); exp_q.push_back(32'h0302_00A2);
    run_op(16'h0200, 16'h0300, 16'd3, 1'b0, 5, 4, 8, 200, cyc);
    check("stall_cycles", cyc, 37);
    check_done_tail("stall", 16'd3);
    check("stall_no_restart", bus.srcValid, 1'b0);
    compare_queues("stall");
    step();

    // source address wrap
    clear_queues();
    exp_src_q.push_back(16'hFFFE); exp_src_q.push_back(16'hFFFF); exp_src_q.push_back(16'h0000);
    exp_q.push_back(32'h0010_00A0); exp_q.push_back(32'h0011_00A1); exp_q.push_back(32'h0012_00A2);
    run_op(16'hFFFE, 16'h0010, 16'd3, 1'b0, 0, 0, -1, 200, cyc);
    check("wrap_cycles", cyc, 10);
    check_done_tail("wrap", 16'd3);
    compare_queues("wrap");
    step();

    // reset while waiting on the second result
    clear_queues();
    exp_q.push_back(32'h0100_00A0);
    bus.offset = 16'h0010; bus.dest = 16'h0100; bus.numOps = 16'd3; bus.writeReverse = 1'b0;
    bus.beginOp = 1'b1;
    step();
    bus.beginOp = 1'b0;
    check("abort_ready_busy", bus.readyForNextOp, 1'b0);
    check("abort_srcValid", bus.srcValid, 1'b1);
    bus.srcReady = 1'b1;
    step();
    bus.srcReady = 1'b0; bus.resValid = 1'b1; bus.resData = 16'h00A0;
    step();
    bus.resValid = 1'b0;
    check("abort_wrEn", bus.wrEn, 1'b1);
    step();
    check("abort_opCount1", bus.opCount, 16'd1);
    bus.srcReady = 1'b1;
    step();
    bus.srcReady = 1'b0;
    check("abort_in_wait", bus.srcValid, 1'b0);
    rst_n = 1'b0;
    step();
    check("abort_ready", bus.readyForNextOp, 1'b1);
    check("abort_opCount", bus.opCount, 16'h0);
    check("abort_srcAddr", bus.srcAddr, 16'h0);
    check("abort_wrAddr", bus.wrAddr, 16'h0);
    check("abort_wrData", bus.wrData, 16'h0);
    check("abort_done", bus.done, 1'b0);
    rst_n = 1'b1;
    bus.resValid = 1'b1; bus.resData = 16'h00BB;
    repeat (3) step();
    bus.resValid = 1'b0;
    step();
    check("abort_late_wrEn", bus.wrEn, 1'b0);
    check("abort_late_ready", bus.readyForNextOp, 1'b1);
    compare_queues("abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/op_sequencer.md
OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, width of cache addresses and op counts.
REQ-002 SHALL have parameter DATA_W, default 16, width of datapath result words.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 SHALL have port beginOp  input  1  single-cycle request to start a layer operation.
REQ-006 SHALL have port readyForNextOp  output  1  high only in IDLE.
REQ-007 SHALL have ports offset, dest, numOps  input  ADDR_W each  source base, destination base, op count from control registers.
REQ-008 SHALL have port writeReverse  input  1  0: destinations ascend from dest; 1: destinations descend.
REQ-009 SHALL have ports srcAddr  output  ADDR_W, srcValid  output  1, srcReady  input  1  operand-fetch handshake to datapath.
REQ-010 SHALL have ports resData  input  DATA_W, resValid  input  1  datapath result return.
REQ-011 SHALL have ports wrAddr  output  ADDR_W, wrData  output  DATA_W, wrEn  output  1  cache write port.
REQ-012 SHALL have ports opCount  output  ADDR_W (ops completed), done  output  1 (one-cycle completion pulse).

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT, WRITE, DONE.
REQ-014 IDLE: on beginOp=1 SHALL latch offset, dest, numOps, writeReverse, clear idx and opCount; go DONE if latched numOps=0, else ISSUE.
REQ-015 beginOp outside IDLE SHALL be ignored; input changes after latching SHALL NOT affect the running op.
REQ-016 ISSUE: srcValid=1, srcAddr=offset+idx mod 2^ADDR_W; stay until srcReady=1, then go WAIT; srcAddr stable while waiting.
REQ-017 WAIT: on resValid=1 SHALL register resData and go WRITE; resValid in any other state SHALL be ignored.
REQ-018 WRITE: wrEn=1 for exactly one cycle, wrData=registered result, wrAddr=dest+idx (writeReverse=0) or dest-idx (writeReverse=1), mod 2^ADDR_W.
REQ-019 WRITE: SHALL increment idx and opCount; go DONE if incremented idx=numOps, else ISSUE.
REQ-020 DONE: done=1 for one cycle, then IDLE; opCount holds until next accepted beginOp.
REQ-021 Minimum latency per op SHALL be 3 cycles (ISSUE, WAIT, WRITE) with srcReady and resValid immediately high; beginOp to done = 3*numOps+1 cycles.
REQ-022 numOps=0xFFFF SHALL run 65535 ops; address wrap SHALL be silent.
REQ-023 srcValid, wrEn, done SHALL be 0 outside their states; no combinational path from any input to wrEn or done.

Reset
REQ-024 rst_n=0 SHALL force IDLE; idx, opCount, latched registers, srcAddr, wrAddr, wrData = 0; srcValid, wrEn, done = 0; readyForNextOp = 1 from the first cycle after reset.
REQ-025 Reset mid-operation SHALL abort with no further write; a late resValid after reset SHALL be ignored.

Structure
REQ-026 State encoding, ADDR_W/DATA_W defaults SHALL live in shared package op_seq_pkg.
REQ-027 Address generation (offset+idx, dest+/-idx) SHALL be sub-module op_addr_gen; everything else in op_sequencer.

Verification
REQ-028 offset=0x0010, dest=0x0100, numOps=3, writeReverse=0, srcReady=resValid=1 one cycle after request, resData=0xA0+idx -> writes (0x0100,0xA0),(0x0101,0xA1),(0x0102,0xA2); done 10 cycles after beginOp; opCount=3.
REQ-029 Same with writeReverse=1, dest=0x0100 -> wrAddr 0x0100, 0x00FF, 0x00FE.
REQ-030 numOps=0 -> no srcValid, no wrEn, done pulse next cycle, readyForNextOp back next cycle.
REQ-031 srcReady held low 5 cycles, resValid delayed 4 cycles, beginOp pulsed mid-op -> srcAddr stable, single write per op, second beginOp ignored.
REQ-032 offset=0xFFFE, numOps=3 -> srcAddr 0xFFFE, 0xFFFF, 0x0000.
REQ-033 rst_n low while in WAIT after 1 write -> IDLE, all outputs at reset values, later resValid produces no write.
